// File: rtl/multi_clk_div.sv
// Multi-channel programmable clock divider: NUM_CH square-wave outputs with rising-edge
// ticks, glitch-free half-period updates, and a global phase-align sync.
module multi_clk_div #(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned DIV_W        = 26,
    parameter int unsigned DEFAULT_HALF = 49_999_999,
    parameter int unsigned CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_100MHz,
    input  logic              reset,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_half,
    output logic              cfg_ack,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    localparam logic [DIV_W-1:0] DEF_H = DIV_W'(DEFAULT_HALF);

    logic [NUM_CH-1:0][DIV_W-1:0] count_q, count_d;
    logic [NUM_CH-1:0][DIV_W-1:0] half_q,  half_d;
    logic [NUM_CH-1:0][DIV_W-1:0] pend_q,  pend_d;
    logic [NUM_CH-1:0]            pend_valid_q, pend_valid_d;
    logic [NUM_CH-1:0]            clk_q, clk_d;
    logic [NUM_CH-1:0]            tick_q, tick_d;
    logic                         ack_q, ack_d;
    logic                         err_q, err_d;

    logic                         cfg_valid;
    logic [NUM_CH-1:0]            restart;
    logic [NUM_CH-1:0]            terminal;
    logic [NUM_CH-1:0]            apply;

    assign cfg_valid = (32'(cfg_ch) < NUM_CH);

    // A channel's half-period may only change at a half-cycle boundary: a restart
    // (sync or disabled) or its terminal count.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            restart[i]  = sync || !en[i];
            terminal[i] = (count_q[i] == half_q[i]);
            apply[i]    = pend_valid_q[i] && (restart[i] || terminal[i]);
        end
    end

    // NOTE: every variable gets a default before any conditional assignment, so no latches are inferred.
    always_comb begin
        count_d      = count_q;
        clk_d        = clk_q;
        tick_d       = '0;
        half_d       = half_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;

        for (int i = 0; i < NUM_CH; i++) begin
            if (restart[i]) begin
                count_d[i] = '0;
                clk_d[i]   = 1'b0;
            end else if (terminal[i]) begin
                count_d[i] = '0;
                clk_d[i]   = ~clk_q[i];
                tick_d[i]  = ~clk_q[i];
            end else begin
                count_d[i] = count_q[i] + DIV_W'(1);
            end

            if (apply[i]) begin
                half_d[i]       = pend_q[i];
                pend_valid_d[i] = 1'b0;
            end
        end

        // A write landing on the same cycle as an apply becomes the next pending value.
        if (cfg_wr && cfg_valid) begin
            pend_d[cfg_ch]       = cfg_half;
            pend_valid_d[cfg_ch] = 1'b1;
        end

        ack_d = cfg_wr && cfg_valid;
        err_d = cfg_wr && !cfg_valid;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            count_q      <= '0;
            clk_q        <= '0;
            tick_q       <= '0;
            half_q       <= {NUM_CH{DEF_H}};
            pend_valid_q <= '0;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            count_q      <= count_d;
            clk_q        <= clk_d;
            tick_q       <= tick_d;
            half_q       <= half_d;
            pend_valid_q <= pend_valid_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
        end
    end

    // NOTE: the pending-value storage has no reset; pend_valid_q gates every use of it.
    always_ff @(posedge clk_100MHz) begin
        pend_q <= pend_d;
    end

    assign clk_out = clk_q;
    assign tick    = tick_q;
    assign cfg_ack = ack_q;
    assign cfg_err = err_q;

endmodule

// File: tb/tb_multi_clk_div.sv
// Randomised scoreboard bench for multi_clk_div: an event-time reference model predicts
// each cycle's outputs, a separate monitor pops and compares them.
module tb_multi_clk_div;

    localparam int NUM_CH       = 3;
    localparam int DIV_W        = 8;
    localparam int DEFAULT_HALF = 4;
    localparam int CH_W         = 2;

    logic              clk_100MHz = 1'b0;
    logic              reset      = 1'b1;
    logic [NUM_CH-1:0] en         = '0;
    logic              sync       = 1'b0;
    logic              cfg_wr     = 1'b0;
    logic [CH_W-1:0]   cfg_ch     = '0;
    logic [DIV_W-1:0]  cfg_half   = '0;
    logic              cfg_ack;
    logic              cfg_err;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;

    multi_clk_div #(
        .NUM_CH      (NUM_CH),
        .DIV_W       (DIV_W),
        .DEFAULT_HALF(DEFAULT_HALF),
        .CH_W        (CH_W)
    ) dut (
        .clk_100MHz(clk_100MHz),
        .reset     (reset),
        .en        (en),
        .sync      (sync),
        .cfg_wr    (cfg_wr),
        .cfg_ch    (cfg_ch),
        .cfg_half  (cfg_half),
        .cfg_ack   (cfg_ack),
        .cfg_err   (cfg_err),
        .clk_out   (clk_out),
        .tick      (tick)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    typedef struct packed {
        logic [NUM_CH-1:0] clk_out;
        logic [NUM_CH-1:0] tick;
        logic              ack;
        logic              err;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    // Reference model: each channel remembers the absolute cycle of its next toggle.
    int m_half [NUM_CH];
    int m_pend [NUM_CH];
    bit m_pv   [NUM_CH];
    bit m_lvl  [NUM_CH];
    int m_next [NUM_CH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_half[i] = DEFAULT_HALF;
            m_pv[i]   = 1'b0;
            m_lvl[i]  = 1'b0;
            m_next[i] = cyc + DEFAULT_HALF + 1;
        end
    endtask

    task automatic model_apply(input int i);
        if (m_pv[i]) begin
            m_half[i] = m_pend[i];
            m_pv[i]   = 1'b0;
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the coming edge.
    task automatic step(input logic [NUM_CH-1:0] en_v, input logic sync_v, input logic wr_v,
                        input logic [CH_W-1:0] ch_v, input logic [DIV_W-1:0] half_v);
        exp_t e;
        @(negedge clk_100MHz);
        en       = en_v;
        sync     = sync_v;
        cfg_wr   = wr_v;
        cfg_ch   = ch_v;
        cfg_half = half_v;
        cyc++;
        e = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sync_v || !en_v[i]) begin
                m_lvl[i] = 1'b0;
                model_apply(i);
                m_next[i] = cyc + m_half[i] + 1;
            end else if (cyc == m_next[i]) begin
                m_lvl[i]  = ~m_lvl[i];
                e.tick[i] = m_lvl[i];
                model_apply(i);
                m_next[i] = cyc + m_half[i] + 1;
            end
            e.clk_out[i] = m_lvl[i];
        end
        if (wr_v) begin
            if (int'(ch_v) < NUM_CH) begin
                m_pend[ch_v] = int'(half_v);
                m_pv[ch_v]   = 1'b1;
                e.ack        = 1'b1;
            end else begin
                e.err = 1'b1;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(en, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic write(input logic [CH_W-1:0] ch_v, input int h);
        step(en, 1'b0, 1'b1, ch_v, DIV_W'(h));
    endtask

    // Monitor: pops one expectation per edge that the stimulus predicted.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_100MHz);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("clk_out@%0d", cyc), 32'(clk_out), 32'(e.clk_out));
                check($sformatf("tick@%0d", cyc),    32'(tick),    32'(e.tick));
                check($sformatf("cfg_ack@%0d", cyc), 32'(cfg_ack), 32'(e.ack));
                check($sformatf("cfg_err@%0d", cyc), 32'(cfg_err), 32'(e.err));
            end
        end
    end

    initial begin
        int guard;
        logic [NUM_CH-1:0] en_cur;

        // Power-on reset state, then release between edges.
        #12;
        check("reset_clk_out", 32'(clk_out), 32'h0);
        check("reset_tick",    32'(tick),    32'h0);
        check("reset_ack_err", {30'h0, cfg_ack, cfg_err}, 32'h0);
        #4 reset = 1'b0;
        model_reset();

        // Default rate on all channels.
        en = '1;
        idle(32);

        // Glitch-free update on ch1 and back-to-back writes on ch2.
        write(2'd1, 1);
        idle(25);
        write(2'd2, 7);
        write(2'd2, 2);
        idle(30);

        // Invalid channel.
        write(2'd3, 0);
        idle(20);

        // Mixed rates then sync alignment; second sync coincides with a write.
        write(2'd0, 4);
        write(2'd1, 1);
        write(2'd2, 9);
        idle(37);
        step('1, 1'b1, 1'b0, '0, '0);
        idle(25);
        write(2'd1, 3);
        step('1, 1'b1, 1'b1, 2'd1, 8'd2);
        idle(30);

        // Disable ch0 while its output is high, then re-enable.
        guard = 0;
        while (!m_lvl[0] && guard < 12) begin
            idle(1);
            guard++;
        end
        check("ch0_high_before_disable", 32'(m_lvl[0]), 32'h1);
        step(3'b110, 1'b0, 1'b0, '0, '0);
        step(3'b110, 1'b0, 1'b0, '0, '0);
        step(3'b111, 1'b0, 1'b0, '0, '0);
        idle(20);

        // Async reset mid-operation discards a pending value on ch2.
        step('1, 1'b1, 1'b0, '0, '0);
        write(2'd2, 0);
        guard = 0;
        while (m_lvl[0] == 0 && m_lvl[1] == 0 && guard < 6) begin
            idle(1);
            guard++;
        end
        @(posedge clk_100MHz);
        #2 reset = 1'b1;
        #1;
        check("midreset_clk_out", 32'(clk_out), 32'h0);
        check("midreset_tick",    32'(tick),    32'h0);
        check("midreset_ack_err", {30'h0, cfg_ack, cfg_err}, 32'h0);
        model_reset();
        #1 reset = 1'b0;
        idle(30);

        // Randomised traffic.
        en_cur = '1;
        for (int k = 0; k < 3000; k++) begin
            logic              s;
            logic              w;
            logic [CH_W-1:0]   ch;
            logic [DIV_W-1:0]  h;
            if ($urandom_range(0, 39) == 0) en_cur[$urandom_range(0, NUM_CH-1)] ^= 1'b1;
            s  = ($urandom_range(0, 149) == 0);
            w  = ($urandom_range(0, 11) == 0);
            ch = CH_W'($urandom_range(0, 3));
            h  = ($urandom_range(0, 7) == 0) ? DIV_W'($urandom_range(0, 30))
                                             : DIV_W'($urandom_range(0, 9));
            step(en_cur, s, w, ch, h);
        end

        @(posedge clk_100MHz);
        #3;
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_clk_div.md
Name: multi_clk_div

Overview:
- Parametrised successor to the fixed 100 MHz-to-1 Hz divider.
- Generates NUM_CH independent square-wave slow clocks from clk_100MHz, each with a runtime-programmable half-period.
- Each channel also provides a single-cycle tick strobe on its rising edge, plus an enable.
- Divisor updates are glitch-free and confirmed by a handshake; a global sync input phase-aligns all channels.
- Feeds LFSR, counter and display demo logic that need several slow rates at once.

Parameters:
- NUM_CH, 4, number of output channels (1..16).
- DIV_W, 26, width of the half-period counter and config value.
- DEFAULT_HALF, 49_999_999, reset half-period terminal value for every channel (1 Hz at 100 MHz).
- CH_W, $clog2(NUM_CH) min 1, width of the channel select.

Ports:
- clk_100MHz  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- en  in  NUM_CH  per-channel run enable.
- sync  in  1  single-cycle pulse; restarts all channels phase-aligned.
- cfg_wr  in  1  single-cycle config write strobe.
- cfg_ch  in  CH_W  target channel of cfg_wr.
- cfg_half  in  DIV_W  new half-period terminal value.
- cfg_ack  out  1  one-cycle pulse, the cycle after cfg_wr, when the write is accepted.
- cfg_err  out  1  one-cycle pulse, the cycle after cfg_wr, when cfg_ch >= NUM_CH.
- clk_out  out  NUM_CH  divided square-wave outputs, registered.
- tick  out  NUM_CH  one-cycle strobes, high in the cycle clk_out[i] becomes 1.

Behaviour:
- **Reset (async, active-high):**
  - Per channel: count=0, clk_out=0, tick=0, half=DEFAULT_HALF, pend_valid=0.
  - cfg_ack=0, cfg_err=0.
  - Reset asserted mid-operation: everything returns immediately to these values, and any pending update is discarded.
- **Period arithmetic:**
  - Half-period value H means clk_out toggles every H+1 cycles, so full period = 2(H+1) cycles.
  - H=0 gives clk_100MHz/2. H=49_999_999 gives 1 Hz.
  - count is DIV_W bits and never exceeds H, so it never wraps.
- **Running channel (en[i]=1):**
  - If count==half: count<=0, clk_out toggles, and tick<=1 iff clk_out was 0.
  - Otherwise count<=count+1 and tick<=0.
  - tick duty: exactly 1 cycle per full period, coincident with the rising edge of clk_out.
- **Disabled channel (en[i]=0):**
  - count<=0, clk_out<=0, tick<=0.
  - A pending update is applied immediately.
  - On re-enable, the first rising edge comes H+1 cycles after en rises.
- **Config write:**
  - On cfg_wr with valid cfg_ch: value goes to pend_half[cfg_ch] and pend_valid<=1.
  - cfg_ack pulses on the next cycle.
  - A second write before application overwrites pend_half; the last write wins.
- **Glitch-free apply:**
  - A pending value is loaded into half only at a terminal count (count==half), or when disabled, or on sync.
  - pend_valid clears at that point.
  - No truncated or extended half-cycle is ever produced; the half-cycle in progress completes with the old value.
- **Invalid channel:** cfg_ch >= NUM_CH produces no state change and a cfg_err pulse instead of cfg_ack.
- **sync:**
  - For all channels: count<=0, clk_out<=0, tick<=0, and any pending value is applied.
  - Enabled channels then produce aligned rising edges after H_i+1 cycles.
- **Priority:** reset > sync > disable > terminal count > increment.
- **Simultaneous cfg_wr and sync:**
  - sync applies the previously pending value.
  - The new write becomes pending, is acked normally, and applies at the next terminal count.
- **Simultaneous cfg_wr and terminal count on the same channel:** the old pend_half is applied, and the new value becomes pending.

Test Plan:
- **Default rate:** DEFAULT_HALF=4, all en=1, after reset → every clk_out has period 10 cycles; tick high 1 cycle, with the first tick at cycle 5 after reset release.
- **Glitch-free update:** ch1 running with H=4; cfg_wr ch1 H=1 at count=2 → cfg_ack next cycle; the current half-cycle still lasts 5 cycles; subsequent period is 4; no half-cycle shorter than 2 cycles.
- **Back-to-back writes:** write ch2 H=7 then H=2 before the terminal count → only H=2 takes effect (period 6); two cfg_ack pulses.
- **Invalid channel:** NUM_CH=3, cfg_ch=3 → cfg_err pulse, no cfg_ack, all periods unchanged.
- **sync alignment:** channels running with H={4,1,9} at arbitrary phases; pulse sync → all clk_out=0; rising edges and ticks at +5, +2, +10 cycles after sync.
- **Disable/reset mid-operation:**
  - en[0]=0 mid-high → clk_out[0]=0 next cycle; re-enable gives first tick after H+1 cycles.
  - Async reset asserted between clock edges → outputs 0 immediately, and a pending value is lost.
